// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with integrated MEM/WB pipeline register.
// Issues loads/stores on a req/ready + rvalid data bus, formats load data and
// freezes the upstream pipeline (stall_mem) while an access is outstanding.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (no bus request, misalign_wb flagged) instead of aligning them down.
module mem_stage #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_mem,
    input  logic          store_mem,
    input  logic [2:0]    funct3_mem,
    input  logic [31:0]   alu_data_mem,
    input  logic [31:0]   rs2_data_mem,
    input  logic [4:0]    rd_mem,
    input  logic          im_to_rf_mem,
    input  logic [31:0]   pc_plus_4_mem,
    output logic          stall_mem,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ready,
    input  logic          dmem_rvalid,
    input  logic [31:0]   dmem_rdata,
    output logic [4:0]    rd_wb,
    output logic          im_to_rf_wb,
    output logic          load_wb,
    output logic [31:0]   pc_plus_4_wb,
    output logic [31:0]   alu_data_wb,
    output logic [31:0]   load_data_wb,
    output logic          misalign_wb
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2
    } state_e;

    state_e        state_q, state_d;

    // Access captured at issue, replayed while the bus withholds ready
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [4:0]    rd_q, rd_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    ofs_q, ofs_d;
    logic          we_q, we_d;

    // MEM/WB pipeline register
    logic [4:0]    rd_wb_q, rd_wb_d;
    logic          im_to_rf_wb_q, im_to_rf_wb_d;
    logic          load_wb_q, load_wb_d;
    logic [31:0]   pc_plus_4_wb_q, pc_plus_4_wb_d;
    logic [31:0]   alu_data_wb_q, alu_data_wb_d;
    logic [31:0]   load_data_wb_q, load_data_wb_d;
    logic          misalign_wb_q, misalign_wb_d;

    logic          op_in;
    logic          trap_in;
    logic [1:0]    a_in;
    logic [AW-1:0] addr_in;
    logic [3:0]    be_in;
    logic [31:0]   wdata_in;

    assign op_in   = load_mem | store_mem;
    assign a_in    = alu_data_mem[1:0];
    assign addr_in = {alu_data_mem[AW-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    // Half with odd address or word not on a 4-byte boundary never reaches the bus
    assign trap_in = (state_q == S_IDLE) && op_in &&
                     ((funct3_mem[1:0] == 2'b01) ? a_in[0] :
                      (funct3_mem[1:0] == 2'b00) ? 1'b0 : (a_in != 2'b00));
`else
    assign trap_in = 1'b0;
`endif

    // Sign/zero-extend the addressed lane of the returned word
    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  a,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = d[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b100:  format_load = {24'h0, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b101:  format_load = {16'h0, h};
            default: format_load = d;
        endcase
    endfunction

    // Byte enables and lane-replicated store data for the incoming access
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the case leaves it unassigned and infers a latch.
        be_in    = 4'b1111;
        wdata_in = rs2_data_mem;
        case (funct3_mem[1:0])
            2'b00: begin
                be_in    = 4'b0001 << a_in;
                wdata_in = {4{rs2_data_mem[7:0]}};
            end
            2'b01: begin
                be_in    = a_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{rs2_data_mem[15:0]}};
            end
            default: ;  // word, and undefined encodings behave as word
        endcase
    end

    // Next-state and capture logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        ofs_d    = ofs_q;
        we_d     = we_q;
        case (state_q)
            S_IDLE: begin
                if (op_in && !trap_in) begin
                    addr_d   = addr_in;
                    be_d     = be_in;
                    wdata_d  = wdata_in;
                    rd_d     = rd_mem;
                    funct3_d = funct3_mem;
                    ofs_d    = a_in;
                    we_d     = !load_mem;  // load wins when both are set
                    if (!dmem_ready) state_d = S_REQ;
                    else if (load_mem) state_d = S_WAIT_R;
                end
            end
            S_REQ: begin
                if (dmem_ready) state_d = we_q ? S_IDLE : S_WAIT_R;
            end
            S_WAIT_R: begin
                if (dmem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs and pipeline stall
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        stall_mem  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_in && !trap_in) begin
                    dmem_req   = 1'b1;
                    dmem_we    = !load_mem;
                    dmem_addr  = addr_in;
                    dmem_be    = be_in;
                    dmem_wdata = wdata_in;
                    stall_mem  = !(dmem_ready && !load_mem);
                end
            end
            S_REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_be    = be_q;
                dmem_wdata = wdata_q;
                stall_mem  = !(dmem_ready && we_q);
            end
            S_WAIT_R: begin
                stall_mem = !dmem_rvalid;
            end
            default: ;
        endcase
    end

    // MEM/WB next values; a stalled cycle is passed on as a bubble
    always_comb begin
        rd_wb_d        = (state_q == S_IDLE) ? rd_mem : rd_q;
        im_to_rf_wb_d  = im_to_rf_mem && !stall_mem && !trap_in;
        load_wb_d      = load_mem && !stall_mem && !trap_in;
        pc_plus_4_wb_d = pc_plus_4_mem;
        alu_data_wb_d  = alu_data_mem;
        misalign_wb_d  = trap_in;
        load_data_wb_d = '0;
        if (state_q == S_WAIT_R && dmem_rvalid)
            load_data_wb_d = format_load(funct3_q, ofs_q, dmem_rdata);
    end

    // State, capture and MEM/WB registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            funct3_q       <= '0;
            ofs_q          <= '0;
            we_q           <= 1'b0;
            rd_wb_q        <= '0;
            im_to_rf_wb_q  <= 1'b0;
            load_wb_q      <= 1'b0;
            pc_plus_4_wb_q <= '0;
            alu_data_wb_q  <= '0;
            load_data_wb_q <= '0;
            misalign_wb_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q        <= state_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            rd_q           <= rd_d;
            funct3_q       <= funct3_d;
            ofs_q          <= ofs_d;
            we_q           <= we_d;
            rd_wb_q        <= rd_wb_d;
            im_to_rf_wb_q  <= im_to_rf_wb_d;
            load_wb_q      <= load_wb_d;
            pc_plus_4_wb_q <= pc_plus_4_wb_d;
            alu_data_wb_q  <= alu_data_wb_d;
            load_data_wb_q <= load_data_wb_d;
            misalign_wb_q  <= misalign_wb_d;
        end
    end

    assign rd_wb        = rd_wb_q;
    assign im_to_rf_wb  = im_to_rf_wb_q;
    assign load_wb      = load_wb_q;
    assign pc_plus_4_wb = pc_plus_4_wb_q;
    assign alu_data_wb  = alu_data_wb_q;
    assign load_data_wb = load_data_wb_q;
    assign misalign_wb  = misalign_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage. Stimulus pushes the expected bus
// transaction and writeback result into queues; a negedge monitor pops and
// compares whenever the DUT accepts a bus request or presents a load/trap result.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_mem, store_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_data_mem, rs2_data_mem, pc_plus_4_mem;
    logic [4:0]  rd_mem;
    logic        im_to_rf_mem;
    logic        stall_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rd_wb;
    logic        im_to_rf_wb, load_wb, misalign_wb;
    logic [31:0] pc_plus_4_wb, alu_data_wb, load_data_wb;

    mem_stage #(.AW(32)) dut (
        .clk(clk), .rst(rst),
        .load_mem(load_mem), .store_mem(store_mem), .funct3_mem(funct3_mem),
        .alu_data_mem(alu_data_mem), .rs2_data_mem(rs2_data_mem), .rd_mem(rd_mem),
        .im_to_rf_mem(im_to_rf_mem), .pc_plus_4_mem(pc_plus_4_mem),
        .stall_mem(stall_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rd_wb(rd_wb), .im_to_rf_wb(im_to_rf_wb), .load_wb(load_wb),
        .pc_plus_4_wb(pc_plus_4_wb), .alu_data_wb(alu_data_wb),
        .load_data_wb(load_data_wb), .misalign_wb(misalign_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic        im;
        logic [31:0] ld_data;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        mis;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    bus_t mb;
    wb_t  mw;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compare accepted bus requests and presented writeback results
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req && dmem_ready) begin
                if (bus_q.size() == 0) fail_now("bus_unexpected");
                else begin
                    mb = bus_q.pop_front();
                    check("bus_we", 32'(dmem_we), 32'(mb.we));
                    check("bus_addr", dmem_addr, mb.addr);
                    check("bus_be", 32'(dmem_be), 32'(mb.be));
                    if (mb.we) check("bus_wdata", dmem_wdata, mb.wdata);
                end
            end
            if (load_wb || misalign_wb) begin
                if (wb_q.size() == 0) fail_now("wb_unexpected");
                else begin
                    mw = wb_q.pop_front();
                    check("wb_rd", 32'(rd_wb), 32'(mw.rd));
                    check("wb_im_to_rf", 32'(im_to_rf_wb), 32'(mw.im));
                    check("wb_load_data", load_data_wb, mw.ld_data);
                    check("wb_alu_data", alu_data_wb, mw.alu);
                    check("wb_pc_plus_4", pc_plus_4_wb, mw.pc);
                    check("wb_misalign", 32'(misalign_wb), 32'(mw.mis));
                end
            end
        end
    end

    task automatic drive_idle();
        load_mem = 1'b0; store_mem = 1'b0; funct3_mem = 3'b000;
        alu_data_mem = '0; rs2_data_mem = '0; rd_mem = '0;
        im_to_rf_mem = 1'b0; pc_plus_4_mem = '0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    // Present one access (called at posedge+1), respond on the bus, count stalls/requests
    task automatic run_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                          input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic exp_req, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_ld,
                          input logic exp_mis, input int exp_stalls, input int exp_reqs);
        int   stalls = 0;
        int   reqs = 0;
        bit   done = 1'b0;
        bit   prev_stall = 1'b0;
        bus_t eb;
        wb_t  ew;
        if (exp_req) begin
            eb.we = st & ~ld; eb.addr = exp_addr; eb.be = exp_be; eb.wdata = exp_wdata;
            bus_q.push_back(eb);
        end
        if (ld || exp_mis) begin
            ew.rd = rd; ew.im = ~exp_mis; ew.ld_data = exp_ld; ew.alu = addr;
            ew.pc = 32'h2000 + 32'(rd); ew.mis = exp_mis;
            wb_q.push_back(ew);
        end
        load_mem = ld; store_mem = st; funct3_mem = f3;
        alu_data_mem = addr; rs2_data_mem = rs2; rd_mem = rd;
        im_to_rf_mem = ld; pc_plus_4_mem = 32'h2000 + 32'(rd);
        for (int c = 0; c < 40; c++) begin
            dmem_ready  = (c >= rdy_dly);
            dmem_rvalid = ld && (c == rdy_dly + rv_dly);
            dmem_rdata  = dmem_rvalid ? rdata : 32'h0;
            @(negedge clk);
            if (prev_stall) begin
                check({nm, "_bubble_im_to_rf"}, 32'(im_to_rf_wb), 32'h0);
                check({nm, "_bubble_load"}, 32'(load_wb), 32'h0);
            end
            if (dmem_req) reqs++;
            if (!stall_mem) begin
                done = 1'b1;
                break;
            end
            stalls++;
            prev_stall = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) fail_now({nm, "_timeout"});
        check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        check({nm, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall_mem), 32'h0);
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_we", 32'(dmem_we), 32'h0);
        check("rst_wb_regs", {27'h0, rd_wb} | 32'(im_to_rf_wb) | 32'(load_wb) | 32'(misalign_wb)
                             | pc_plus_4_wb | alu_data_wb | load_data_wb, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle pass-through; rvalid while idle must be ignored
        rd_mem = 5'd7; im_to_rf_mem = 1'b1; alu_data_mem = 32'h55; pc_plus_4_mem = 32'h1004;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("idle_stall", 32'(stall_mem), 32'h0);
        check("idle_req", 32'(dmem_req), 32'h0);
        @(negedge clk);
        check("idle_rd_wb", 32'(rd_wb), 32'h7);
        check("idle_im_to_rf_wb", 32'(im_to_rf_wb), 32'h1);
        check("idle_alu_wb", alu_data_wb, 32'h55);
        check("idle_pc_wb", pc_plus_4_wb, 32'h1004);
        check("idle_load_data_wb", load_data_wb, 32'h0);
        @(posedge clk); #1;
        drive_idle();

        //      name   ld    st    f3      addr          rs2           rd  rdy rv rdata          req  exp_addr      be       wdata         load_data     mis  stl req
        run_op("sw",   1'b0, 1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 5'd1, 0, 0, 32'h0,          1'b1, 32'h104, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0, 0, 1);
        run_op("lb",   1'b1, 1'b0, 3'b000, 32'h103, 32'h0,         5'd2, 0, 1, 32'h80FF_0000,  1'b1, 32'h100, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0, 1, 1);
        run_op("lhu",  1'b1, 1'b0, 3'b101, 32'h202, 32'h0,         5'd3, 3, 2, 32'hABCD_1234,  1'b1, 32'h200, 4'b1100, 32'h0,         32'h0000_ABCD, 1'b0, 5, 4);
        run_op("sb",   1'b0, 1'b1, 3'b000, 32'h301, 32'h55,        5'd4, 0, 0, 32'h0,          1'b1, 32'h300, 4'b0010, 32'h5555_5555, 32'h0,         1'b0, 0, 1);
        run_op("sh",   1'b0, 1'b1, 3'b001, 32'h106, 32'h1234,      5'd5, 2, 0, 32'h0,          1'b1, 32'h104, 4'b1100, 32'h1234_1234, 32'h0,         1'b0, 2, 3);
        run_op("lh",   1'b1, 1'b0, 3'b001, 32'h102, 32'h0,         5'd6, 0, 1, 32'h8001_0000,  1'b1, 32'h100, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0, 1, 1);
        run_op("lbu",  1'b1, 1'b0, 3'b100, 32'h101, 32'h0,         5'd7, 0, 1, 32'h0000_AB00,  1'b1, 32'h100, 4'b0010, 32'h0,         32'h0000_00AB, 1'b0, 1, 1);
        run_op("ldst", 1'b1, 1'b1, 3'b010, 32'h10C, 32'hFFFF_FFFF, 5'd8, 1, 1, 32'h1234_5678,  1'b1, 32'h10C, 4'b1111, 32'h0,         32'h1234_5678, 1'b0, 2, 2);
`ifdef MISALIGN_TRAP_EN
        run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h302, 32'h0,       5'd9, 0, 1, 32'hCAFE_F00D,  1'b0, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1, 0, 0);
        run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0,       5'd10, 0, 1, 32'h8001_2222, 1'b0, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1, 0, 0);
`else
        run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h302, 32'h0,       5'd9, 0, 1, 32'hCAFE_F00D,  1'b1, 32'h300, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0, 1, 1);
        run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0,       5'd10, 0, 1, 32'h8001_2222, 1'b1, 32'h100, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0, 1, 1);
`endif
        run_op("s_f3u", 1'b0, 1'b1, 3'b011, 32'h208, 32'h0BAD_F00D, 5'd11, 0, 0, 32'h0,        1'b1, 32'h208, 4'b1111, 32'h0BAD_F00D, 32'h0,         1'b0, 0, 1);

        // Reset while a load waits for rvalid; the late rvalid must be ignored
        load_mem = 1'b1; funct3_mem = 3'b010; alu_data_mem = 32'h200; rd_mem = 5'd12;
        im_to_rf_mem = 1'b1; pc_plus_4_mem = 32'h200C; dmem_ready = 1'b1;
        mb.we = 1'b0; mb.addr = 32'h200; mb.be = 4'b1111; mb.wdata = 32'h0;
        bus_q.push_back(mb);
        @(negedge clk);
        check("rstmid_stall_pre", 32'(stall_mem), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        #1;
        check("rstmid_stall", 32'(stall_mem), 32'h0);
        check("rstmid_req", 32'(dmem_req), 32'h0);
        check("rstmid_wb_regs", {27'h0, rd_wb} | 32'(im_to_rf_wb) | 32'(load_wb) | 32'(misalign_wb)
                                | pc_plus_4_wb | alu_data_wb | load_data_wb, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        check("stale_rvalid_stall", 32'(stall_mem), 32'h0);
        check("stale_rvalid_req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("stale_rvalid_load_wb", 32'(load_wb), 32'h0);
        check("stale_rvalid_load_data", load_data_wb, 32'h0);

        repeat (2) @(negedge clk);
        check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
        check("wb_queue_drained", 32'(wb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
